// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and its 8N1 receiver.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CSUM,
        FIN
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling timer and LSB-first shift register.
module uart_rx_8n1
    import loader_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk_i,
    input  logic       nclr_i,
    input  logic       rxd_i,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rxs;

    assign rxs = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (!nclr_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            prev_q  <= rxs;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line held low after a framing error must not retrigger.
                if (prev_q && !rxs) begin
                    state_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rxs;
                    ferr_d  = !rxs;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program image (A5, N, data[, checksum]) from UART into instruction memory.
// Optional checksum byte and CSUM state are built when LOADER_CHECKSUM_EN is defined.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic              FPGA_GlobalClock,
    input  logic              NCLR,
    input  logic              UART_RXD,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              LOAD_BUSY,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    localparam int          DIV       = calc_div(CLK_HZ, BAUD);
    localparam int          TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_8n1 #(
        .DIV(DIV)
    ) u_rx (
        .clk_i   (FPGA_GlobalClock),
        .nclr_i  (NCLR),
        .rxd_i   (UART_RXD),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [8:0]        left_q, left_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic       fail;
    logic       timeout;
    logic [8:0] n_len;

    assign timeout = (to_q == TO_W'(TIMEOUT_CYC));
    assign n_len   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!NCLR) begin
            state_q <= IDLE;
            idx_q   <= '0;
            left_q  <= '0;
            to_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            to_q    <= to_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        left_d  = left_q;
        to_d    = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fail    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // Inter-byte timer runs only inside a frame; an arriving byte always wins over expiry.
        if (state_q == COUNT || state_q == DATA || state_q == CSUM) begin
            to_d = rx_valid ? '0 : to_q + 1'b1;
            if (!rx_valid && (rx_ferr || timeout)) begin
                fail = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = COUNT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    if (32'(n_len) > MEM_DEPTH) begin
                        fail = 1'b1;
                    end else begin
                        left_d  = n_len;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = rx_data;
                    idx_d   = idx_q + 1'b1;
                    left_d  = left_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + rx_data;
                    if (left_q == 9'd1) state_d = CSUM;
`else
                    if (left_q == 9'd1) state_d = FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) state_d = FIN;
                    else                  fail    = 1'b1;
                end
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fail) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign LOAD_BUSY = busy_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader; adapts frames to the LOADER_CHECKSUM_EN setting.
module tb_uart_program_loader;

    localparam int DIV = 10;

    logic       clk  = 1'b0;
    logic       nclr = 1'b0;
    logic       rxd  = 1'b1;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       load_busy;
    logic       load_done;
    logic       load_err;

    uart_program_loader #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .ADDR_W     (8),
        .TIMEOUT_CYC(500)
    ) dut (
        .FPGA_GlobalClock(clk),
        .NCLR            (nclr),
        .UART_RXD        (rxd),
        .MEM_WE          (mem_we),
        .MEM_ADDR        (mem_addr),
        .MEM_WDATA       (mem_wdata),
        .LOAD_BUSY       (load_busy),
        .LOAD_DONE       (load_done),
        .LOAD_ERR        (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_w;
    logic [7:0] tx_q[$];
    int         n_vec    = 0;
    int         n_bad    = 0;
    int         done_cnt = 0;
    int         d0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (nclr && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", mem_addr, exp_w.addr);
                chk("wr_data", mem_wdata, exp_w.data);
            end
        end
        if (nclr && load_done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        rxd = 1'b1;
        repeat (DIV) @(posedge clk);
    endtask

    task automatic flush_tx();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},    mem_we,    0);
        chk({tag, "_addr"},  mem_addr,  0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"},  load_busy, 0);
        chk({tag, "_done"},  load_done, 0);
        chk({tag, "_err"},   load_err,  0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) nclr = 1'b1;
        repeat (20) @(posedge clk);

        // 1: good 3-byte frame
        d0 = done_cnt;
        expect_wr(8'd0, 8'h11);
        expect_wr(8'd1, 8'h22);
        expect_wr(8'd2, 8'h33);
        send_byte(8'hA5, 1'b1);
        chk("t1_busy_after_sync", load_busy, 1);
        tx_q = '{8'h03, 8'h11, 8'h22, 8'h33};
        flush_tx();
`ifdef LOADER_CHECKSUM_EN
        chk("t1_busy_before_csum", load_busy, 1);
        send_byte(8'h66, 1'b1);
`endif
        repeat (5) @(posedge clk);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", load_err, 0);
        chk("t1_busy_end", load_busy, 0);

`ifdef LOADER_CHECKSUM_EN
        // 2: bad checksum, then a good frame clears the error on its sync byte
        d0 = done_cnt;
        expect_wr(8'd0, 8'h11);
        expect_wr(8'd1, 8'h22);
        expect_wr(8'd2, 8'h33);
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        flush_tx();
        repeat (5) @(posedge clk);
        chk("t2_done", done_cnt - d0, 0);
        chk("t2_err", load_err, 1);
        chk("t2_busy", load_busy, 0);
        send_byte(8'hA5, 1'b1);
        chk("t2_err_cleared", load_err, 0);
        d0 = done_cnt;
        expect_wr(8'd0, 8'h5A);
        tx_q = '{8'h01, 8'h5A, 8'h5A};
        flush_tx();
        repeat (5) @(posedge clk);
        chk("t2_good_done", done_cnt - d0, 1);
`endif

        // 3: noise bytes before sync are ignored
        d0 = done_cnt;
        tx_q = '{8'h00, 8'hFF};
        flush_tx();
        chk("t3_idle_busy", load_busy, 0);
        expect_wr(8'd0, 8'h7E);
        tx_q = '{8'hA5, 8'h01, 8'h7E};
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(8'h7E);
`endif
        flush_tx();
        repeat (5) @(posedge clk);
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_err", load_err, 0);

        // 4: inter-byte timeout
        d0 = done_cnt;
        expect_wr(8'd0, 8'h10);
        tx_q = '{8'hA5, 8'h02, 8'h10};
        flush_tx();
        chk("t4_busy_wait", load_busy, 1);
        repeat (600) @(posedge clk);
        chk("t4_err", load_err, 1);
        chk("t4_busy", load_busy, 0);
        chk("t4_done", done_cnt - d0, 0);

        // 5: short glitch is no byte; stop bit low is a framing error
        d0 = done_cnt;
        tx_q = '{8'hA5, 8'h02};
        flush_tx();
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        chk("t5_busy_after_glitch", load_busy, 1);
        chk("t5_err_after_glitch", load_err, 0);
        send_byte(8'h3C, 1'b0);
        repeat (5) @(posedge clk);
        chk("t5_err", load_err, 1);
        chk("t5_busy", load_busy, 0);
        chk("t5_done", done_cnt - d0, 0);

        // 6: reset mid-DATA, then a clean reload
        expect_wr(8'd0, 8'hAA);
        tx_q = '{8'hA5, 8'h02, 8'hAA};
        flush_tx();
        chk("t6_busy_mid", load_busy, 1);
        @(negedge clk) nclr = 1'b0;
        @(posedge clk);
        #1 check_all_zero("t6_reset");
        @(negedge clk) nclr = 1'b1;
        repeat (5) @(posedge clk);
        d0 = done_cnt;
        expect_wr(8'd0, 8'h55);
        tx_q = '{8'hA5, 8'h01, 8'h55};
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(8'h55);
`endif
        flush_tx();
        repeat (5) @(posedge clk);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_err", load_err, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
